myproject_mul_pipe: RTL and testbench

Parametrised, pipelined, flow-controlled multiplier for the myproject datapath. It is the successor to the fixed-width, single-cycle `mul_*ns_*s` primitives. Operand widths, output width, per-operand signedness and pipeline depth are all parameters. It carries a valid/ready handshake with full backpressure, so dense and VAE layers can place it on stall-capable streams instead of relying on a global clock enable. An optional compile-time accumulate mode turns it into a dot-product MAC.

---
 rtl/myproject_mul_pipe_pkg.sv | 34 +++
 rtl/myproject_mul_pipe_reg.sv | 40 ++++
 rtl/myproject_mul_pipe.sv | 158 +++++++++++++++
 tb/tb_myproject_mul_pipe.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/myproject_mul_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | myproject_mul_pkg : shared widths, sign encoding and parameter checks |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package myproject_mul_pkg;

  typedef enum logic {
    OPND_UNSIGNED = 1'b0,
    OPND_SIGNED   = 1'b1
  } opnd_sign_e;

  localparam int DEF_DIN0_WIDTH  = 31;
  localparam int DEF_DIN1_WIDTH  = 16;
  localparam int DEF_DOUT_WIDTH  = 47;
  localparam int DEF_DIN0_SIGNED = 0;
  localparam int DEF_DIN1_SIGNED = 1;
  localparam int DEF_NUM_STAGE   = 3;

  // One extension bit per operand keeps the signed product exact.
  function automatic int mul_full_width(input int w0, input int w1);
    return w0 + w1 + 2;
  endfunction

  function automatic bit stage_ok(input int n);
    return n >= 1;
  endfunction

  function automatic bit dout_width_ok(input int d, input int w0, input int w1);
    return (d >= 1) && (d <= mul_full_width(w0, w1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/myproject_mul_pipe_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | myproject_pipe_reg : one valid+data pipeline stage with enable        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module myproject_pipe_reg
  import myproject_mul_pkg::*;
#(
  parameter int WIDTH = DEF_DOUT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Data only moves with a valid beat; bubbles leave the old value in place.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/myproject_mul_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | myproject_mul_pipe : pipelined valid/ready multiplier, optional MAC   |
// | Build option: MYPROJECT_MUL_ACC_EN enables dot-product accumulation.  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module myproject_mul_pipe
  import myproject_mul_pkg::*;
#(
  parameter int DIN0_WIDTH  = DEF_DIN0_WIDTH,
  parameter int DIN1_WIDTH  = DEF_DIN1_WIDTH,
  parameter int DOUT_WIDTH  = DEF_DOUT_WIDTH,
  parameter int DIN0_SIGNED = DEF_DIN0_SIGNED,
  parameter int DIN1_SIGNED = DEF_DIN1_SIGNED,
  parameter int NUM_STAGE   = DEF_NUM_STAGE
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout
);

  localparam int FULL_W = mul_full_width(DIN0_WIDTH, DIN1_WIDTH);
`ifdef MYPROJECT_MUL_ACC_EN
  localparam int LAST_W = 1;
`else
  localparam int LAST_W = 0;
`endif
  localparam int DATA_W = DOUT_WIDTH + LAST_W;

  generate
    if (!stage_ok(NUM_STAGE)) begin : g_bad_stage
      $error("myproject_mul_pipe: NUM_STAGE must be at least 1");
    end
    if (!dout_width_ok(DOUT_WIDTH, DIN0_WIDTH, DIN1_WIDTH)) begin : g_bad_dout
      $error("myproject_mul_pipe: DOUT_WIDTH out of range");
    end
  endgenerate

  logic signed [DIN0_WIDTH:0] w_a_ext;
  logic signed [DIN1_WIDTH:0] w_b_ext;

  generate
    if (DIN0_SIGNED == int'(OPND_SIGNED)) begin : g_a_sext
      assign w_a_ext = {din0[DIN0_WIDTH-1], din0};
    end else begin : g_a_zext
      assign w_a_ext = {1'b0, din0};
    end
    if (DIN1_SIGNED == int'(OPND_SIGNED)) begin : g_b_sext
      assign w_b_ext = {din1[DIN1_WIDTH-1], din1};
    end else begin : g_b_zext
      assign w_b_ext = {1'b0, din1};
    end
  endgenerate

  logic signed [FULL_W-1:0]     w_a_full;
  logic signed [FULL_W-1:0]     w_b_full;
  logic signed [FULL_W-1:0]     w_prod;
  logic        [DOUT_WIDTH-1:0] w_p;
  logic                         w_unused;

  assign w_a_full = FULL_W'(w_a_ext);
  assign w_b_full = FULL_W'(w_b_ext);
  assign w_prod   = w_a_full * w_b_full;
  assign w_p      = w_prod[DOUT_WIDTH-1:0];
  assign w_unused = ^{w_prod, in_last};

  logic                r_out_valid;
  logic [DOUT_WIDTH-1:0] r_dout;
  logic                w_en;

  // The whole pipe stalls together, so ready never sees in_valid.
  assign w_en     = out_ready | ~r_out_valid;
  assign in_ready = w_en;

  logic              w_vld [NUM_STAGE];
  logic [DATA_W-1:0] w_dat [NUM_STAGE];

  assign w_vld[0] = in_valid;
`ifdef MYPROJECT_MUL_ACC_EN
  assign w_dat[0] = {in_last, w_p};
`else
  assign w_dat[0] = w_p;
`endif

  generate
    for (genvar gi = 1; gi < NUM_STAGE; gi++) begin : g_stage
      myproject_pipe_reg #(
        .WIDTH (DATA_W)
      ) u_reg (
        .i_clk   (ap_clk),
        .i_rst_n (ap_rst_n),
        .i_en    (w_en),
        .i_valid (w_vld[gi-1]),
        .i_data  (w_dat[gi-1]),
        .o_valid (w_vld[gi]),
        .o_data  (w_dat[gi])
      );
    end
  endgenerate

  logic                  w_fin_vld;
  logic [DOUT_WIDTH-1:0] w_fin_p;

  assign w_fin_vld = w_vld[NUM_STAGE-1];
  assign w_fin_p   = w_dat[NUM_STAGE-1][DOUT_WIDTH-1:0];

`ifdef MYPROJECT_MUL_ACC_EN
  logic                  w_fin_last;
  logic [DOUT_WIDTH-1:0] r_acc;
  logic [DOUT_WIDTH-1:0] w_sum;

  assign w_fin_last = w_dat[NUM_STAGE-1][DOUT_WIDTH];
  assign w_sum      = r_acc + w_fin_p;

  // Non-last beats fold into the accumulator silently; the last one emits and clears.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_acc       <= '0;
    end else if (w_en) begin
      r_out_valid <= w_fin_vld & w_fin_last;
      if (w_fin_vld) begin
        if (w_fin_last) begin
          r_dout <= w_sum;
          r_acc  <= '0;
        end else begin
          r_acc  <= w_sum;
        end
      end
    end
  end
`else
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_out_valid <= 1'b0;
      r_dout      <= '0;
    end else if (w_en) begin
      r_out_valid <= w_fin_vld;
      if (w_fin_vld) begin
        r_dout <= w_fin_p;
      end
    end
  end
`endif

  assign out_valid = r_out_valid;
  assign dout      = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_myproject_mul_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_myproject_mul_pipe : scoreboard bench for default and 1-stage DUTs |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_myproject_mul_pipe;

`ifdef MYPROJECT_MUL_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic        rst_n, in_valid, in_ready, in_last, out_valid, out_ready;
  logic [30:0] din0;
  logic [15:0] din1;
  logic [46:0] dout;

  logic        rst1_n, in_valid1, in_ready1, in_last1, out_valid1, out_ready1;
  logic [30:0] din0_1;
  logic [15:0] din1_1;
  logic [46:0] dout1;

  myproject_mul_pipe u_dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout)
  );

  myproject_mul_pipe #(
    .DIN0_SIGNED (1),
    .DIN1_SIGNED (1),
    .NUM_STAGE   (1)
  ) u_dut1 (
    .ap_clk    (ap_clk),
    .ap_rst_n  (rst1_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .din0      (din0_1),
    .din1      (din1_1),
    .in_last   (in_last1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .dout      (dout1)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [46:0] q0 [$];
  logic [46:0] q1 [$];
  bit          done1 = 1'b0;
  bit          rnd1  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired, required the event to occur", name);
  endtask

  task automatic drive0(input logic [30:0] a, input logic [15:0] b, input logic last,
                        input logic [46:0] exp);
    int n = 0;
    @(negedge ap_clk);
    in_valid = 1'b1; din0 = a; din1 = b; in_last = last;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge ap_clk); #1; n++;
    end
    if (!in_ready) fail_timeout("accept0");
    else if (!ACC || last) q0.push_back(exp);
  endtask

  task automatic drain0();
    int n = 0;
    @(negedge ap_clk);
    in_valid = 1'b0;
    while (q0.size() != 0 && n < 200) begin
      @(negedge ap_clk); n++;
    end
    if (q0.size() != 0) fail_timeout("drain0");
    repeat (5) @(negedge ap_clk);
  endtask

  task automatic drive1(input logic [30:0] a, input logic [15:0] b, input logic [46:0] exp);
    int n = 0;
    @(negedge ap_clk);
    in_valid1 = 1'b1; din0_1 = a; din1_1 = b; in_last1 = 1'b1;
    #1;
    while (!in_ready1 && n < 50) begin
      @(negedge ap_clk); #1; n++;
    end
    if (!in_ready1) fail_timeout("accept1");
    else q1.push_back(exp);
  endtask

  // Monitors sample 2 time units after the falling edge, well away from posedge.
  initial begin : mon0
    bit          prev_stall;
    logic [46:0] prev_dout;
    prev_stall = 1'b0;
    prev_dout  = '0;
    forever begin
      @(negedge ap_clk); #2;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        check("in_ready_rule", {63'd0, in_ready}, {63'd0, out_ready | ~out_valid});
        if (prev_stall) begin
          check("stall_valid_hold", {63'd0, out_valid}, 64'd1);
          check("stall_dout_hold", {17'd0, dout}, {17'd0, prev_dout});
        end
        if (out_valid && out_ready) begin
          if (q0.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_output0: got 0x%0h, required no output", dout);
          end else begin
            check("dout0", {17'd0, dout}, {17'd0, q0.pop_front()});
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_dout  = dout;
      end
    end
  end

  initial begin : mon1
    bit          prev_stall;
    logic [46:0] prev_dout;
    prev_stall = 1'b0;
    prev_dout  = '0;
    forever begin
      @(negedge ap_clk); #2;
      if (!rst1_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("n1_stall_valid_hold", {63'd0, out_valid1}, 64'd1);
          check("n1_stall_dout_hold", {17'd0, dout1}, {17'd0, prev_dout});
        end
        if (out_valid1 && out_ready1) begin
          if (q1.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_output1: got 0x%0h, required no output", dout1);
          end else begin
            check("dout1", {17'd0, dout1}, {17'd0, q1.pop_front()});
          end
        end
        prev_stall = out_valid1 && !out_ready1;
        prev_dout  = dout1;
      end
    end
  end

  initial begin : rdy1
    forever begin
      @(negedge ap_clk);
      if (rnd1) out_ready1 = ($urandom_range(0, 1) == 1);
    end
  end

  // Single-stage signed x signed instance, hand-computed table.
  initial begin : stim1
    logic [30:0] ta [6];
    logic [15:0] tb [6];
    logic [46:0] te [6];
    int          n;
    ta = '{31'd3, 31'h7FFF_FFFD, 31'h7FFF_FFFF, 31'h4000_0000, 31'h3FFF_FFFF, 31'd7};
    tb = '{16'hFFFE, 16'd5, 16'hFFFF, 16'h8000, 16'h7FFF, 16'd9};
    te = '{47'h7FFF_FFFF_FFFA, 47'h7FFF_FFFF_FFF1, 47'd1,
           47'h2000_0000_0000, 47'h1FFF_BFFF_8001, 47'd63};
    rst1_n = 1'b0; in_valid1 = 1'b0; in_last1 = 1'b1; out_ready1 = 1'b1;
    din0_1 = '0; din1_1 = '0;
    repeat (3) @(negedge ap_clk);
    rst1_n = 1'b1;
    drive1(ta[0], tb[0], te[0]);
    @(negedge ap_clk);
    in_valid1 = 1'b0;
    check("n1_latency", {63'd0, out_valid1}, 64'd1);
    rnd1 = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) drive1(ta[i], tb[i], te[i]);
    end
    @(negedge ap_clk);
    in_valid1 = 1'b0;
    n = 0;
    while (q1.size() != 0 && n < 300) begin
      @(negedge ap_clk); n++;
    end
    if (q1.size() != 0) fail_timeout("drain1");
    rnd1 = 1'b0;
    out_ready1 = 1'b1;
    repeat (4) @(negedge ap_clk);
    done1 = 1'b1;
  end

  initial begin : stim0
    int k, cyc, n;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b1; out_ready = 1'b1;
    din0 = '0; din1 = '0;
    repeat (3) @(negedge ap_clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_dout", {17'd0, dout}, 64'd0);
    rst_n = 1'b1;
    #1 check("ready_after_rst", {63'd0, in_ready}, 64'd1);

    drive0(31'h7FFF_FFFF, 16'h8000, 1'b1, 47'h4000_0000_8000);
    @(negedge ap_clk);
    in_valid = 1'b0;
    check("latency_c1", {63'd0, out_valid}, 64'd0);
    @(negedge ap_clk);
    check("latency_c2", {63'd0, out_valid}, 64'd0);
    @(negedge ap_clk);
    check("latency_c3", {63'd0, out_valid}, 64'd1);

    drive0(31'd3, 16'hFFFE, 1'b1, 47'h7FFF_FFFF_FFFA);
    drive0(31'h7FFF_FFFF, 16'h0001, 1'b1, 47'h0000_7FFF_FFFF);
    drive0(31'h7FFF_FFFF, 16'h7FFF, 1'b1, 47'h3FFF_7FFF_8001);
    drive0(31'd5, 16'hFFFF, 1'b1, 47'h7FFF_FFFF_FFFB);
    drain0();

    // Eight beats, downstream stalled for cycles 5..8 once the pipe is full.
    k = 1; cyc = 0;
    while (k <= 8 && cyc < 100) begin
      @(negedge ap_clk);
      out_ready = !(cyc >= 5 && cyc < 9);
      in_valid = 1'b1; din0 = 31'(k); din1 = 16'd1; in_last = 1'b1;
      #1;
      if (cyc >= 5 && cyc < 9) check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      else check("bp_in_ready_high", {63'd0, in_ready}, 64'd1);
      if (in_ready) begin
        q0.push_back(47'(k));
        k++;
      end
      cyc++;
    end
    if (k <= 8) fail_timeout("bp_accept");
    out_ready = 1'b1;
    drain0();

    drive0(31'd2, 16'd3, 1'b1, 47'd6);
    drive0(31'd4, 16'd5, 1'b1, 47'd20);
    drive0(31'd6, 16'd7, 1'b1, 47'd42);
    @(negedge ap_clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_dout", {17'd0, dout}, 64'd0);
    q0.delete();
    repeat (2) @(negedge ap_clk);
    out_ready = 1'b1; rst_n = 1'b1;
    #1 check("ready_after_rst2", {63'd0, in_ready}, 64'd1);
    drive0(31'd5, 16'd5, 1'b1, 47'd25);
    drain0();

`ifdef MYPROJECT_MUL_ACC_EN
    drive0(31'd1, 16'd1, 1'b0, 47'd0);
    drive0(31'd2, 16'd2, 1'b0, 47'd0);
    drive0(31'd3, 16'd3, 1'b0, 47'd0);
    drive0(31'd4, 16'd4, 1'b1, 47'd30);
    drive0(31'd7, 16'd1, 1'b1, 47'd7);
    drain0();
`endif

    n = 0;
    while (!done1 && n < 3000) begin
      @(negedge ap_clk); n++;
    end
    if (!done1) fail_timeout("done1");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
